// File: rtl/uart_auth.sv
// 8N1 UART receiver feeding the Segway power-up/power-down authorization FSM.
// pwr_up is registered from the next auth state, so it never glitches.
module uart_auth #(
   parameter int unsigned BAUD_DIV = 2604,
   parameter logic [7:0]  CMD_GO   = 8'h47,
   parameter logic [7:0]  CMD_STOP = 8'h53
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   input  logic       rider_off,
   output logic       pwr_up,
   output logic [7:0] rx_data,
   output logic       rx_rdy
);

   localparam logic [11:0] LP_FULL = 12'(BAUD_DIV);
   localparam logic [11:0] LP_HALF = 12'(BAUD_DIV / 2);

   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHi} rx_state_e;
   typedef enum logic [1:0] {AuthOff, AuthPwr1, AuthPwr2} auth_state_e;

   logic        r_rx_meta, r_rx_s;
   rx_state_e   r_rx_state, w_rx_state_d;
   logic [11:0] r_cnt, w_cnt_d;
   logic [2:0]  r_idx, w_idx_d;
   logic [7:0]  r_shift, w_shift_d;
   logic [7:0]  r_rx_data, w_rx_data_d;
   logic        r_rx_rdy, w_rx_rdy_d;
   auth_state_e r_auth, w_auth_d;
   logic        r_pwr_up;
   logic        w_expire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta  <= 1'b1;
         r_rx_s     <= 1'b1;
         r_rx_state <= RxIdle;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_shift    <= '0;
         r_rx_data  <= '0;
         r_rx_rdy   <= 1'b0;
         r_auth     <= AuthOff;
         r_pwr_up   <= 1'b0;
      end else begin
         r_rx_meta  <= RX;
         r_rx_s     <= r_rx_meta;
         r_rx_state <= w_rx_state_d;
         r_cnt      <= w_cnt_d;
         r_idx      <= w_idx_d;
         r_shift    <= w_shift_d;
         r_rx_data  <= w_rx_data_d;
         r_rx_rdy   <= w_rx_rdy_d;
         r_auth     <= w_auth_d;
         r_pwr_up   <= (w_auth_d != AuthOff);
      end
   end

   assign w_expire = (r_cnt == 12'd1);

   always_comb begin
      w_rx_state_d = r_rx_state;
      w_cnt_d      = r_cnt;
      w_idx_d      = r_idx;
      w_shift_d    = r_shift;
      w_rx_data_d  = r_rx_data;
      w_rx_rdy_d   = 1'b0;
      case (r_rx_state)
         RxIdle: begin
            if (!r_rx_s) begin
               w_rx_state_d = RxStart;
               w_cnt_d      = LP_HALF;
            end
         end
         RxStart: begin
            if (w_expire) begin
               // A start bit that is high again at mid-bit was only a glitch.
               if (!r_rx_s) begin
                  w_rx_state_d = RxData;
                  w_idx_d      = 3'd0;
                  w_cnt_d      = LP_FULL;
               end else begin
                  w_rx_state_d = RxIdle;
               end
            end else begin
               w_cnt_d = r_cnt - 12'd1;
            end
         end
         RxData: begin
            if (w_expire) begin
               w_shift_d[r_idx] = r_rx_s;
               w_cnt_d          = LP_FULL;
               if (r_idx == 3'd7) w_rx_state_d = RxStop;
               else               w_idx_d      = r_idx + 3'd1;
            end else begin
               w_cnt_d = r_cnt - 12'd1;
            end
         end
         RxStop: begin
            if (w_expire) begin
               if (r_rx_s) begin
                  w_rx_data_d  = r_shift;
                  w_rx_rdy_d   = 1'b1;
                  w_rx_state_d = RxIdle;
               end else begin
                  w_rx_state_d = RxWaitHi;
               end
            end else begin
               w_cnt_d = r_cnt - 12'd1;
            end
         end
         RxWaitHi: begin
            if (r_rx_s) w_rx_state_d = RxIdle;
         end
         default: w_rx_state_d = RxIdle;
      endcase
   end

   always_comb begin
      w_auth_d = r_auth;
      case (r_auth)
         AuthOff: begin
            if (r_rx_rdy && (r_rx_data == CMD_GO)) w_auth_d = AuthPwr1;
         end
         AuthPwr1: begin
            if (r_rx_rdy && (r_rx_data == CMD_STOP)) w_auth_d = rider_off ? AuthOff : AuthPwr2;
         end
         AuthPwr2: begin
            if (r_rx_rdy && (r_rx_data == CMD_GO)) w_auth_d = AuthPwr1;
            else if (rider_off)                    w_auth_d = AuthOff;
         end
         default: w_auth_d = AuthOff;
      endcase
   end

   assign pwr_up  = r_pwr_up;
   assign rx_data = r_rx_data;
   assign rx_rdy  = r_rx_rdy;

endmodule
